// File: rtl/xbar_req_pool_pkg.sv
// Shared types for the crossbar request pool: channel request payload and default pool depth.
package xbar_req_pool_pkg;

   localparam int XBAR_POOL_DEPTH_DEF = 8;

   typedef struct packed {
      logic [2:0]   op;
      logic [31:0]  addr;
      logic [127:0] data;
   } channel_req_t;

endpackage

// File: rtl/xbar_req_pool_ch.sv
// One upstream channel of the request pool: entry store, valid bitmap, lowest-free allocator,
// N_BANK read ports and merged bank releases. XBAR_REQ_POOL_OCC_EN adds occupancy counters.
module xbar_req_pool_ch
   import xbar_req_pool_pkg::*;
#(
   parameter  int N_BANK = 4,
   parameter  int DEPTH  = XBAR_POOL_DEPTH_DEF,
   localparam int ID_W   = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_req_valid,
   input  channel_req_t                 i_req,
   output logic                         o_req_ready,
   output logic [ID_W-1:0]              o_w_entry_id,
   output logic [DEPTH-1:0]             o_entry_vld,
   input  logic [N_BANK-1:0]            i_bank_sel,
   input  logic [N_BANK-1:0][DEPTH-1:0] i_bank_entry_1hot,
   input  logic [N_BANK-1:0]            i_bank_release,
   output logic [N_BANK-1:0]            o_bank_vld,
   output channel_req_t [N_BANK-1:0]    o_bank_req
`ifdef XBAR_REQ_POOL_OCC_EN
   ,
   input  logic                         i_occ_max_clr,
   output logic [ID_W:0]                o_occ,
   output logic [ID_W:0]                o_occ_max
`endif
);

   function automatic logic [DEPTH-1:0] lowest_1hot(input logic [DEPTH-1:0] v);
      return v & (~v + DEPTH'(1));
   endfunction

   function automatic logic [ID_W-1:0] onehot2bin(input logic [DEPTH-1:0] oh);
      logic [ID_W-1:0] bin;
      bin = '0;
      for (int i = 0; i < DEPTH; i++)
         if (oh[i]) bin = bin | ID_W'(i);
      return bin;
   endfunction

   channel_req_t                   r_mem [DEPTH];
   logic [DEPTH-1:0]               r_vld;
   logic [DEPTH-1:0]               w_free_1hot;
   logic [DEPTH-1:0]               w_set;
   logic [DEPTH-1:0]               w_clr;
   logic                           w_hs;
   logic [N_BANK-1:0][DEPTH-1:0]   w_rd_1hot;
   logic [N_BANK-1:0][ID_W-1:0]    w_rd_id;

   // Allocation sees only the registered bitmap, so a release never reaches ready in the same cycle.
   // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      w_free_1hot  = lowest_1hot(~r_vld);
      o_w_entry_id = onehot2bin(w_free_1hot);
      o_req_ready  = ~&r_vld;
      w_hs         = i_req_valid & o_req_ready;
      w_set        = w_hs ? w_free_1hot : '0;
   end

   always_comb begin
      w_rd_1hot  = '0;
      w_rd_id    = '0;
      o_bank_vld = '0;
      o_bank_req = '0;
      w_clr      = '0;
      for (int b = 0; b < N_BANK; b++) begin
         w_rd_1hot[b]  = lowest_1hot(i_bank_entry_1hot[b]);
         w_rd_id[b]    = onehot2bin(w_rd_1hot[b]);
         o_bank_vld[b] = (|i_bank_entry_1hot[b]) & r_vld[w_rd_id[b]];
         o_bank_req[b] = o_bank_vld[b] ? r_mem[w_rd_id[b]] : '0;
         // Several banks hitting one entry merge into a single clear.
         if (i_bank_sel[b] & i_bank_release[b] & o_bank_vld[b])
            w_clr = w_clr | w_rd_1hot[b];
      end
   end

   assign o_entry_vld = r_vld;

   // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_vld <= '0;
      else        r_vld <= (r_vld & ~w_clr) | w_set;
   end

   // NOTE: the payload array is reset too, so its contents are defined 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_hs) begin
         r_mem[o_w_entry_id] <= i_req;
      end
   end

`ifdef XBAR_REQ_POOL_OCC_EN
   localparam int CNT_W = ID_W + 1;

   logic [ID_W:0] r_occ;
   logic [ID_W:0] r_occ_max;
   logic [ID_W:0] w_occ_nxt;

   // w_clr only ever holds valid entries, so its popcount is the number of effective releases.
   always_comb w_occ_nxt = r_occ + CNT_W'(w_hs) - CNT_W'($countones(w_clr));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ     <= '0;
         r_occ_max <= '0;
      end else begin
         r_occ <= w_occ_nxt;
         if (i_occ_max_clr)              r_occ_max <= '0;
         else if (w_occ_nxt > r_occ_max) r_occ_max <= w_occ_nxt;
      end
   end

   assign o_occ     = r_occ;
   assign o_occ_max = r_occ_max;
`endif

endmodule

// File: rtl/xbar_req_pool.sv
// Per-channel request pool for the crossbar: channel instances plus the per-bank channel mux.
// Optional occupancy outputs (ch_occ, ch_occ_max, occ_max_clr) under XBAR_REQ_POOL_OCC_EN.
module xbar_req_pool
   import xbar_req_pool_pkg::*;
#(
   parameter  int N_CH   = 3,
   parameter  int N_BANK = 4,
   parameter  int DEPTH  = XBAR_POOL_DEPTH_DEF,
   localparam int ID_W   = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_CH-1:0]               u_ch_req_valid,
   output logic [N_CH-1:0]               u_ch_req_ready,
   input  channel_req_t [N_CH-1:0]       u_ch_req,
   output logic [N_CH-1:0][ID_W-1:0]     u_ch_w_entry_id,
   output logic [N_CH-1:0][DEPTH-1:0]    ch_entry_vld,
   input  logic [N_BANK-1:0][N_CH-1:0]   bank_ch_1hot_id,
   input  logic [N_BANK-1:0][DEPTH-1:0]  bank_r_entry_1hot_id,
   input  logic [N_BANK-1:0]             bank_release,
   output logic [N_BANK-1:0]             d_bank_req_valid,
   output channel_req_t [N_BANK-1:0]     d_bank_req
`ifdef XBAR_REQ_POOL_OCC_EN
   ,
   input  logic                          occ_max_clr,
   output logic [N_CH-1:0][ID_W:0]       ch_occ,
   output logic [N_CH-1:0][ID_W:0]       ch_occ_max
`endif
);

   function automatic logic [N_CH-1:0] lowest_ch(input logic [N_CH-1:0] v);
      return v & (~v + N_CH'(1));
   endfunction

   logic [N_BANK-1:0][N_CH-1:0]       w_bank_ch_sel;
   logic [N_CH-1:0][N_BANK-1:0]       w_ch_bank_sel;
   logic [N_CH-1:0][N_BANK-1:0]       w_ch_bank_vld;
   channel_req_t [N_CH-1:0][N_BANK-1:0] w_ch_bank_req;

   // Selector decode is kept apart from the data mux so no block both feeds and reads a channel.
   always_comb begin
      w_bank_ch_sel = '0;
      w_ch_bank_sel = '0;
      for (int b = 0; b < N_BANK; b++) begin
         w_bank_ch_sel[b] = lowest_ch(bank_ch_1hot_id[b]);
         for (int c = 0; c < N_CH; c++) w_ch_bank_sel[c][b] = w_bank_ch_sel[b][c];
      end
   end

   always_comb begin
      d_bank_req_valid = '0;
      d_bank_req       = '0;
      for (int b = 0; b < N_BANK; b++)
         for (int c = 0; c < N_CH; c++)
            if (w_bank_ch_sel[b][c]) begin
               d_bank_req_valid[b] = w_ch_bank_vld[c][b];
               d_bank_req[b]       = w_ch_bank_req[c][b];
            end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      xbar_req_pool_ch #(
         .N_BANK (N_BANK),
         .DEPTH  (DEPTH)
      ) u_ch (
         .clk               (clk),
         .rst_n             (rst_n),
         .i_req_valid       (u_ch_req_valid[c]),
         .i_req             (u_ch_req[c]),
         .o_req_ready       (u_ch_req_ready[c]),
         .o_w_entry_id      (u_ch_w_entry_id[c]),
         .o_entry_vld       (ch_entry_vld[c]),
         .i_bank_sel        (w_ch_bank_sel[c]),
         .i_bank_entry_1hot (bank_r_entry_1hot_id),
         .i_bank_release    (bank_release),
         .o_bank_vld        (w_ch_bank_vld[c]),
         .o_bank_req        (w_ch_bank_req[c])
`ifdef XBAR_REQ_POOL_OCC_EN
         ,
         .i_occ_max_clr     (occ_max_clr),
         .o_occ             (ch_occ[c]),
         .o_occ_max         (ch_occ_max[c])
`endif
      );
   end

endmodule
